// File: rtl/ascii_num_tx_if.sv
// ascii_num_tx_if: request side (valid/ready, value, hex, newline) and character side (valid/ready, char, last)
interface ascii_num_tx_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_value;
  logic             in_hex;
  logic             in_newline;
  logic             out_valid;
  logic             out_ready;
  logic [6:0]       out_char;
  logic             out_last;
  modport master (output in_valid, in_value, in_hex, in_newline, out_ready, input in_ready, out_valid, out_char, out_last);
  modport slave (input in_valid, in_value, in_hex, in_newline, out_ready, output in_ready, out_valid, out_char, out_last);
endinterface

// File: rtl/ascii_num_tx.sv
// ascii_num_tx: formats one value per request as decimal or uppercase hex ASCII with optional CR LF; ports clk, rst_n, bus (slave)
module ascii_num_tx #(
  parameter int WIDTH      = 16,
  parameter int DEC_DIGITS = 5
) (
  input logic          clk,
  input logic          rst_n,
  ascii_num_tx_if.slave bus
);
  localparam int DW = 4 * DEC_DIGITS;
  localparam int IW = $clog2(DEC_DIGITS + 1);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {IDLE, CONV, EMIT, CR, LF} state_t;
  state_t           state;
  logic [DW-1:0]    dg, adj, bcd_next, ld;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx, idx_m1, msd;
  logic             nl, last;
  logic [6:0]       ch;
  function automatic logic [6:0] ascii(input logic [3:0] d);
    return d <= 4'd9 ? 7'h30 + {3'b000, d} : 7'h37 + {3'b000, d};
  endfunction
  always_comb begin
    adj = dg;
    for (int i = 0; i < DEC_DIGITS; i++)
      adj[4*i +: 4] = dg[4*i +: 4] >= 4'd5 ? dg[4*i +: 4] + 4'd3 : dg[4*i +: 4];
    bcd_next = DW'({adj, sh[WIDTH-1]});
    ld = state == IDLE ? DW'(bus.in_value) : bcd_next;
    msd = '0;
    for (int i = 0; i < DEC_DIGITS; i++)
      if (ld[4*i +: 4] != 4'd0) msd = IW'(i);
    idx_m1 = idx - IW'(1);
  end
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == EMIT || state == CR || state == LF;
  assign bus.out_char  = ch;
  assign bus.out_last  = last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dg    <= '0;
      sh    <= '0;
      cnt   <= '0;
      idx   <= '0;
      nl    <= 1'b0;
      ch    <= '0;
      last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          nl    <= bus.in_newline;
          sh    <= bus.in_value;
          cnt   <= CW'(WIDTH - 1);
          dg    <= bus.in_hex ? ld : '0;
          idx   <= msd;
          state <= bus.in_hex ? EMIT : CONV;
          ch    <= bus.in_hex ? ascii(ld[{msd, 2'b00} +: 4]) : 7'h00;
          last  <= bus.in_hex && msd == '0 && !bus.in_newline;
        end
        CONV: begin
          dg  <= bcd_next;
          sh  <= sh << 1;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state <= EMIT;
            idx   <= msd;
            ch    <= ascii(ld[{msd, 2'b00} +: 4]);
            last  <= msd == '0 && !nl;
          end
        end
        EMIT: if (bus.out_ready) begin
          if (idx == '0) begin
            state <= nl ? CR : IDLE;
            ch    <= nl ? 7'h0D : 7'h00;
            last  <= 1'b0;
          end else begin
            idx  <= idx_m1;
            ch   <= ascii(dg[{idx_m1, 2'b00} +: 4]);
            last <= idx_m1 == '0 && !nl;
          end
        end
        CR: if (bus.out_ready) begin
          state <= LF;
          ch    <= 7'h0A;
          last  <= 1'b1;
        end
        LF: if (bus.out_ready) begin
          state <= IDLE;
          ch    <= 7'h00;
          last  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ascii_num_tx.md
Name: ascii_num_tx

Overview:
- Transmitter-side counterpart to the ASCII character classifier.
- Accepts one binary value per handshake and emits it as a stream of 7-bit ASCII characters, one per accepted output beat.
- Output is decimal or uppercase hex, with leading zeros suppressed and an optional CR LF terminator.
- Sits between status/debug logic and a character sink such as a UART TX or a console buffer. Downstream classifiers can check the output stream: is_num for digits, is_cap for hex letters.

Parameters:
- WIDTH, 16, bit width of in_value. Must be a multiple of 4 and in the range 4..32.
- DEC_DIGITS, 5, decimal digit slots. Must be at least ceil(WIDTH*log10(2)); 5 for WIDTH=16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- in_value  input  WIDTH  value to format
- in_hex  input  1  1 = hex, 0 = unsigned decimal
- in_newline  input  1  1 = append CR (0x0D) then LF (0x0A)
- out_valid  output  1  out_char valid
- out_ready  input  1  sink accepts out_char
- out_char  output  7  ASCII code
- out_last  output  1  final character of the current string

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - While rst_n=0: state=IDLE, out_valid=0, out_last=0, out_char=7'h00, all internal registers cleared.
  - in_ready=1 in IDLE, including during reset.
- Input handshake:
  - Request accepted on a rising edge with in_valid && in_ready.
  - in_value, in_hex and in_newline are captured on that edge.
  - in_ready=1 only in IDLE; no request is accepted while a string is in progress.
- States: IDLE, CONV, EMIT, CR, LF.
- IDLE:
  - On accept with in_hex=1, go to EMIT.
  - On accept with in_hex=0, go to CONV.
- CONV (decimal only):
  - Iterative double-dabble: one input bit per cycle, MSB first.
  - Runs exactly WIDTH cycles, then goes to EMIT.
  - BCD register is 4*DEC_DIGITS bits. Before each shift, add 3 to every nibble >= 5.
- EMIT:
  - Digit index starts at the most significant nonzero digit. This is found by a priority encoder on state entry, at no cycle cost.
  - If the value is 0, exactly one '0' (0x30) is emitted.
  - Digit d maps to 0x30+d for d<=9 and to 0x41+(d-10) for d in 10..15 (uppercase 'A'-'F'; no lowercase).
  - Hex digit count is WIDTH/4; decimal digit count is DEC_DIGITS.
  - The index advances only on out_valid && out_ready.
  - After the least significant digit is accepted: go to CR if newline was captured, else to IDLE.
- CR: emit 0x0D; on accept go to LF.
- LF: emit 0x0A; on accept go to IDLE.
- out_valid=1 throughout EMIT, CR and LF.
- out_last=1 on the final character only: the LS digit when newline=0, the LF when newline=1.
- Latency, with accept edge = cycle 0:
  - Hex: first out_valid in cycle 1.
  - Decimal: first out_valid in cycle WIDTH+1.
  - Zero-stall throughput is one character per cycle.
  - After the final accept, in_ready=1 in the next cycle. There are no back-to-back strings in the same cycle.
- Backpressure: while out_valid && !out_ready, out_char, out_last and the state are held stable for any number of cycles.
- Simultaneous events:
  - in_valid during EMIT, CR or LF is ignored (in_ready=0).
  - in_valid in the same cycle as the final out accept is not accepted; it is accepted in the following IDLE cycle.
- Reset mid-operation: immediate return to reset values. A partially emitted string is discarded and is not resumed.
- Inputs are sampled only on the accept edge. Changes to in_value afterwards have no effect.

Test Plan:
1. Decimal, no newline: in_value=16'd12345, in_hex=0, out_ready=1 -> first out_valid at cycle 17. Chars 0x31,0x32,0x33,0x34,0x35 on consecutive cycles; out_last only on 0x35; in_ready=1 the next cycle.
2. Hex with leading zeros: in_value=16'h00AF, in_hex=1 -> chars 0x41,0x46 starting at cycle 1, out_last on 0x46. Then in_value=16'hBEEF -> 0x42,0x45,0x45,0x46.
3. Zero and maximum values:
   - in_value=0 with decimal and with hex -> single char 0x30 with out_last.
   - in_value=16'hFFFF decimal with in_newline=1 -> 0x36,0x35,0x35,0x33,0x35,0x0D,0x0A, out_last only on 0x0A.
4. Backpressure: hex 16'h1234 with out_ready=0 for 3 cycles on each char -> out_char is held stable while stalled. The sequence 0x31..0x34 has no duplicates or drops; in_ready=0 throughout.
5. Ignored request: in_valid=1 with a new value during EMIT -> not captured. The current string completes unchanged, then the new request is accepted in IDLE and output correctly.
6. Reset mid-string: rst_n=0 asynchronously after the second char of decimal 12345 -> out_valid=0 immediately and in_ready=1. After release, a new request for 16'd7 yields a single 0x37 with out_last.
